// File: rtl/accum_ctrl_pkg.sv
// Shared definitions for the partial-sum accumulator sequencer.
//   state_e      : controller state encoding
//   *_DEF        : default geometry used by the layer top
//   TAG_*        : bit positions inside the delay-line tag {valid, j, first, last}
package accum_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int LWIDTH_DEF  = 10;
  localparam int WAWIDTH_DEF = 20;
  localparam int LAT_DEF     = 3;

  // Low end of the tag; j sits between these and the valid bit on top.
  localparam int TAG_LAST  = 0;
  localparam int TAG_FIRST = 1;
  localparam int TAG_J_LSB = 2;

endpackage

// File: rtl/accum_ctrl_if.sv
// Bundle between the layer-level control FSM and the accumulator sequencer.
//   master : layer control (drives start/in_len/out_len, observes the rest)
//   slave  : accum_ctrl (drives handshake status, addresses and strobes)
interface accum_ctrl_if #(
  parameter int LWIDTH  = 10,
  parameter int WAWIDTH = 20
);
  logic               start;
  logic [LWIDTH-1:0]  in_len;
  logic [LWIDTH-1:0]  out_len;
  logic               busy;
  logic               done;
  logic [WAWIDTH-1:0] w_addr;
  logic [LWIDTH-1:0]  x_addr;
  logic               issue;
  logic [LWIDTH-1:0]  buf_raddr;
  logic               buf_re;
  logic [LWIDTH-1:0]  buf_waddr;
  logic               buf_we;
  logic               acc_first;
  logic               acc_we;

  modport master (
    output start, in_len, out_len,
    input  busy, done, w_addr, x_addr, issue,
    input  buf_raddr, buf_re, buf_waddr, buf_we, acc_first, acc_we
  );

  modport slave (
    input  start, in_len, out_len,
    output busy, done, w_addr, x_addr, issue,
    output buf_raddr, buf_re, buf_waddr, buf_we, acc_first, acc_we
  );
endinterface

// File: rtl/accum_ctrl_delay.sv
// Tag delay line that aligns issue-time information with the datapath.
//   clk, reset : clock, synchronous active-high reset (clears every stage)
//   din        : tag entering at issue time
//   rd_tag     : top RW bits of the tag, delayed DEPTH-1 cycles (read slot)
//   wr_tag     : full tag, delayed DEPTH cycles (write-back slot)
module accum_ctrl_delay #(
  parameter int W     = 13,
  parameter int DEPTH = 3,
  parameter int RW    = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  din,
  output logic [RW-1:0] rd_tag,
  output logic [W-1:0]  wr_tag
);

  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  // stage_q[k] holds the tag issued k+1 cycles ago.
  assign rd_tag = stage_q[DEPTH-2][W-1 -: RW];
  assign wr_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/accum_ctrl.sv
// Partial-sum accumulator sequencer for the fully-connected layer.
// Walks i (outer, 0..in_len-1) x j (inner, 0..out_len-1), issuing weight and
// input addresses, then replays each issue LAT-1 cycles later as a buffer read
// and LAT cycles later as a write-back with the accumulator strobes.
//   clk, reset : clock, synchronous active-high reset
//   bus        : accum_ctrl_if.slave (start/len in; busy/done, addresses, strobes out)
// LAT must lie in 2..8.
//
// state    | meaning
// ST_IDLE  | waiting for start, lengths latched on acceptance
// ST_RUN   | issuing (i,j) pairs, one per cycle (every other cycle if out_len==1)
// ST_DRAIN | last issue sent, waiting LAT cycles for its write-back
// ST_DONE  | one-cycle done pulse
module accum_ctrl
  import accum_ctrl_pkg::*;
#(
  parameter int LWIDTH  = LWIDTH_DEF,
  parameter int WAWIDTH = WAWIDTH_DEF,
  parameter int LAT     = LAT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  accum_ctrl_if.slave  bus
);

  localparam int TW = LWIDTH + 3;
  localparam int RW = LWIDTH + 1;

  state_e             state_q, state_d;
  logic [LWIDTH-1:0]  in_len_q, in_len_d;
  logic [LWIDTH-1:0]  out_len_q, out_len_d;
  logic [LWIDTH-1:0]  i_q, i_d;
  logic [LWIDTH-1:0]  j_q, j_d;
  logic [WAWIDTH-1:0] w_addr_q, w_addr_d;
  logic               bubble_q, bubble_d;
  logic [3:0]         drain_q, drain_d;

  logic               issue;
  logic               last_i;
  logic               last_j;
  logic               zero_len;
  logic [TW-1:0]      tag_in;
  logic [RW-1:0]      rd_tag;
  logic [TW-1:0]      wr_tag;

  // Out_len==1 would read j=0 again before its write-back lands, so a bubble
  // follows every issue in that case.
  assign issue    = (state_q == ST_RUN) && !bubble_q;
  assign last_i   = (i_q == in_len_q - LWIDTH'(1));
  assign last_j   = (j_q == out_len_q - LWIDTH'(1));
  assign zero_len = (bus.in_len == '0) || (bus.out_len == '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = zero_len ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue && last_i && last_j) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Loop counters, latched lengths and drain timer
  always_comb begin
    in_len_d  = in_len_q;
    out_len_d = out_len_q;
    i_d       = i_q;
    j_d       = j_q;
    w_addr_d  = w_addr_q;
    bubble_d  = 1'b0;
    drain_d   = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          in_len_d  = bus.in_len;
          out_len_d = bus.out_len;
          i_d       = '0;
          j_d       = '0;
          w_addr_d  = '0;
        end
      end
      ST_RUN: begin
        // Loaded so the first DRAIN cycle sees LAT-1 and the write-back of the
        // final issue lands on the last DRAIN cycle.
        drain_d  = 4'(LAT - 1);
        bubble_d = issue && (out_len_q == LWIDTH'(1));
        if (issue) begin
          w_addr_d = w_addr_q + WAWIDTH'(1);
          if (last_j) begin
            j_d = '0;
            if (!last_i) begin
              i_d = i_q + LWIDTH'(1);
            end
          end else begin
            j_d = j_q + LWIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q != '0) begin
          drain_d = drain_q - 4'd1;
        end
      end
      ST_DONE: begin
        i_d      = '0;
        j_d      = '0;
        w_addr_d = '0;
      end
      default: begin
        drain_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_len_q  <= '0;
      out_len_q <= '0;
      i_q       <= '0;
      j_q       <= '0;
      w_addr_q  <= '0;
      bubble_q  <= 1'b0;
      drain_q   <= '0;
    end else begin
      in_len_q  <= in_len_d;
      out_len_q <= out_len_d;
      i_q       <= i_d;
      j_q       <= j_d;
      w_addr_q  <= w_addr_d;
      bubble_q  <= bubble_d;
      drain_q   <= drain_d;
    end
  end

  // Idle slots carry an all-zero tag so delayed addresses rest at 0.
  assign tag_in = issue ? {1'b1, j_q, (i_q == '0), last_i} : '0;

  accum_ctrl_delay #(
    .W     (TW),
    .DEPTH (LAT),
    .RW    (RW)
  ) u_delay (
    .clk    (clk),
    .reset  (reset),
    .din    (tag_in),
    .rd_tag (rd_tag),
    .wr_tag (wr_tag)
  );

  // Output logic
  always_comb begin
    bus.busy      = (state_q != ST_IDLE);
    bus.done      = (state_q == ST_DONE);
    bus.issue     = issue;
    bus.w_addr    = w_addr_q;
    bus.x_addr    = i_q;
    bus.buf_re    = rd_tag[RW-1];
    bus.buf_raddr = rd_tag[RW-2:0];
    bus.buf_we    = wr_tag[TW-1];
    bus.buf_waddr = wr_tag[TW-2:TAG_J_LSB];
    bus.acc_first = wr_tag[TW-1] & wr_tag[TAG_FIRST];
    bus.acc_we    = wr_tag[TW-1] & wr_tag[TAG_LAST];
  end

endmodule

// File: tb/tb_accum_ctrl.sv
// Directed bench for accum_ctrl with LAT=3. A negedge monitor records every
// issue, read and write-back relative to the start cycle; a linear sequence of
// passes then compares those records against hand-derived schedules.
module tb_accum_ctrl;

  localparam int LW  = 10;
  localparam int WAW = 20;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  accum_ctrl_if #(.LWIDTH(LW), .WAWIDTH(WAW)) bus ();

  accum_ctrl #(.LWIDTH(LW), .WAWIDTH(WAW), .LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit rec = 1'b0;
  int t0 = 0;
  int rst_rel_g = -1;
  int iss_rel[$], iss_wa[$], iss_xa[$];
  int rd_rel[$], rd_a[$];
  int wr_rel[$], wr_a[$], wr_first[$], wr_we[$];
  int done_rel[$];
  int busy_cnt, stray, dirty;

  always @(negedge clk) begin
    int rel;
    if (rec) begin
      rel = cyc - t0;
      if (bus.issue) begin
        iss_rel.push_back(rel);
        iss_wa.push_back(int'(bus.w_addr));
        iss_xa.push_back(int'(bus.x_addr));
      end
      if (bus.buf_re) begin
        rd_rel.push_back(rel);
        rd_a.push_back(int'(bus.buf_raddr));
      end
      if (bus.buf_we) begin
        wr_rel.push_back(rel);
        wr_a.push_back(int'(bus.buf_waddr));
        wr_first.push_back(int'(bus.acc_first));
        wr_we.push_back(int'(bus.acc_we));
      end
      if (bus.done) done_rel.push_back(rel);
      if (bus.busy) busy_cnt++;
      if ((bus.acc_first || bus.acc_we) && !bus.buf_we) stray++;
      if (rst_rel_g >= 0 && rel > rst_rel_g &&
          (bus.busy || bus.done || bus.issue || bus.buf_re || bus.buf_we ||
           bus.acc_first || bus.acc_we || bus.w_addr != '0 || bus.x_addr != '0 ||
           bus.buf_raddr != '0 || bus.buf_waddr != '0))
        dirty++;
    end
  end

  task automatic check(string tag, int obs, int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pass: start at rel 0, then run a fixed window of cycles. xs1/xs2 are
  // cycles where start is re-pulsed with bogus lengths; rst_rel pulses reset.
  task automatic run_pass(int nin, int nout, int window, int xs1, int xs2, int rst_rel);
    iss_rel.delete(); iss_wa.delete(); iss_xa.delete();
    rd_rel.delete(); rd_a.delete();
    wr_rel.delete(); wr_a.delete(); wr_first.delete(); wr_we.delete();
    done_rel.delete();
    busy_cnt = 0; stray = 0; dirty = 0;
    rst_rel_g = rst_rel;
    @(posedge clk); #1;
    bus.in_len  = LW'(nin);
    bus.out_len = LW'(nout);
    bus.start   = 1'b1;
    t0  = cyc;
    rec = 1'b1;
    for (int r = 1; r <= window; r++) begin
      @(posedge clk); #1;
      bus.start = (r == xs1 || r == xs2);
      if (bus.start) begin
        bus.in_len  = LW'(7);
        bus.out_len = LW'(7);
      end
      reset = (r == rst_rel);
    end
    rec = 1'b0;
    bus.start = 1'b0;
    reset = 1'b0;
  endtask

  // Expected schedule: issue k at rel 1+k*step, read LAT-1 later, write LAT later.
  task automatic check_run(string tag, int nin, int nout);
    int n, step, last, m;
    n    = nin * nout;
    step = (nout == 1) ? 2 : 1;
    last = (n == 0) ? 1 : 1 + (n - 1) * step + LAT + 1;
    check({tag, ".issues"}, iss_rel.size(), n);
    check({tag, ".reads"},  rd_rel.size(),  n);
    check({tag, ".writes"}, wr_rel.size(),  n);
    check({tag, ".dones"},  done_rel.size(), 1);
    if (done_rel.size() > 0) check({tag, ".done_cyc"}, done_rel[0], last);
    check({tag, ".busy_cycles"}, busy_cnt, last);
    check({tag, ".stray_acc"}, stray, 0);
    m = (iss_rel.size() < n) ? iss_rel.size() : n;
    for (int k = 0; k < m; k++) begin
      check($sformatf("%s.iss_cyc[%0d]", tag, k), iss_rel[k], 1 + k * step);
      check($sformatf("%s.w_addr[%0d]", tag, k), iss_wa[k], k);
      check($sformatf("%s.x_addr[%0d]", tag, k), iss_xa[k], k / nout);
    end
    m = (rd_rel.size() < n) ? rd_rel.size() : n;
    for (int k = 0; k < m; k++) begin
      check($sformatf("%s.rd_cyc[%0d]", tag, k), rd_rel[k], 1 + k * step + LAT - 1);
      check($sformatf("%s.raddr[%0d]", tag, k), rd_a[k], k % nout);
    end
    m = (wr_rel.size() < n) ? wr_rel.size() : n;
    for (int k = 0; k < m; k++) begin
      check($sformatf("%s.wr_cyc[%0d]", tag, k), wr_rel[k], 1 + k * step + LAT);
      check($sformatf("%s.waddr[%0d]", tag, k), wr_a[k], k % nout);
      check($sformatf("%s.first[%0d]", tag, k), wr_first[k], int'(k / nout == 0));
      check($sformatf("%s.acc_we[%0d]", tag, k), wr_we[k], int'(k / nout == nin - 1));
    end
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.in_len = '0;
    bus.out_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.busy",      int'(bus.busy), 0);
    check("rst.done",      int'(bus.done), 0);
    check("rst.issue",     int'(bus.issue), 0);
    check("rst.buf_re",    int'(bus.buf_re), 0);
    check("rst.buf_we",    int'(bus.buf_we), 0);
    check("rst.acc_first", int'(bus.acc_first), 0);
    check("rst.acc_we",    int'(bus.acc_we), 0);
    check("rst.w_addr",    int'(bus.w_addr), 0);
    check("rst.x_addr",    int'(bus.x_addr), 0);
    check("rst.raddr",     int'(bus.buf_raddr), 0);
    check("rst.waddr",     int'(bus.buf_waddr), 0);
    reset = 1'b0;

    run_pass(3, 4, 24, -1, -1, -1);
    check_run("p3x4", 3, 4);

    run_pass(2, 1, 14, -1, -1, -1);
    check_run("p2x1", 2, 1);
    if (wr_rel.size() > 0 && rd_rel.size() > 1)
      check("p2x1.raw_order", int'(wr_rel[0] < rd_rel[1]), 1);
    cnt = 0;
    foreach (wr_we[k]) cnt += wr_we[k];
    check("p2x1.acc_we_count", cnt, 1);

    run_pass(0, 4, 8, -1, -1, -1);
    check_run("p0x4", 0, 4);
    run_pass(3, 0, 8, -1, -1, -1);
    check_run("p3x0", 3, 0);

    // Restart attempts mid-RUN and in the DONE cycle must be ignored.
    run_pass(3, 4, 24, 4, 16, -1);
    check_run("restart", 3, 4);

    // Reset during cycle of issue index 4: nothing may emerge afterwards.
    run_pass(3, 4, 12, -1, -1, 5);
    check("abort.issues", iss_rel.size(), 5);
    check("abort.reads",  rd_rel.size(), 3);
    check("abort.writes", wr_rel.size(), 2);
    check("abort.dones",  done_rel.size(), 0);
    check("abort.dirty_cycles", dirty, 0);

    run_pass(3, 4, 24, -1, -1, -1);
    check_run("after_abort", 3, 4);

    run_pass(1, 5, 16, -1, -1, -1);
    check_run("p1x5", 1, 5);
    cnt = 0;
    foreach (wr_we[k]) cnt += wr_we[k] & wr_first[k];
    check("p1x5.first_and_we", cnt, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
